// File: rtl/cntr_sample_monitor.sv
// Sample monitor for the counter/clock-divider block: checks each channel steps by +1,
// keeps a saturating mismatch count, and queues on-demand snapshots in a small FIFO.
module cntr_sample_monitor #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_B,
    input  logic [WIDTH-1:0]     CNTR_IN1,
    input  logic [WIDTH-1:0]     CNTR_IN2,
    input  logic [WIDTH-1:0]     CNTR_IN3,
    input  logic                 SELECT_3,
    input  logic                 CHK_EN,
    input  logic                 ERR_CLR,
    input  logic                 SNAP_REQ,
    output logic [3*WIDTH-1:0]   SNAP_DATA,
    output logic                 SNAP_VALID,
    input  logic                 SNAP_READY,
    output logic [ERRW-1:0]      ERR_CNT,
    output logic                 ERR_FLAG,
    output logic                 OVF,
    output logic                 FIFO_FULL
);
    // state | meaning
    // IDLE  | checker off, waiting for CHK_EN
    // ARM   | load prev registers from inputs, no compare
    // CHECK | compare inputs against prev+1, reload prev
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   prev1_q, prev1_d, prev2_q, prev2_d, prev3_q, prev3_d;
    logic               sel3_q, sel3_d;
    logic [ERRW-1:0]    err_cnt_q, err_cnt_d;
    logic               err_flag_q, err_flag_d;
    logic               ovf_q, ovf_d;
    logic [3*WIDTH-1:0] mem_q [DEPTH];
    logic [3*WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]        count_q, count_d;

    logic do_cmp, mis1, mis2, mis3, mismatch;
    logic pop, full, drop, wr_en;

    always_comb begin
        state_d = state_q;
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        prev3_d = prev3_q;
        sel3_d  = SELECT_3;
        do_cmp  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CHK_EN) state_d = S_ARM;
            end
            S_ARM: begin
                prev1_d = CNTR_IN1;
                prev2_d = CNTR_IN2;
                prev3_d = CNTR_IN3;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!CHK_EN) begin
                    state_d = S_IDLE;
                end else begin
                    do_cmp  = 1'b1;
                    prev1_d = CNTR_IN1;
                    prev2_d = CNTR_IN2;
                    prev3_d = CNTR_IN3;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mis1 = CNTR_IN1 != prev1_q + WIDTH'(1);
        mis2 = CNTR_IN2 != prev2_q + WIDTH'(1);
        // ch3 carries bypass data unless it was a counter on both this and the last sample
        mis3 = SELECT_3 && sel3_q && (CNTR_IN3 != prev3_q + WIDTH'(1));
        mismatch = do_cmp && (mis1 || mis2 || mis3);
    end

    always_comb begin
        pop   = (count_q != '0) && SNAP_READY;
        full  = count_q == FULL_CNT;
        drop  = SNAP_REQ && full && !pop;
        wr_en = SNAP_REQ && !drop;

        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = {CNTR_IN3, CNTR_IN2, CNTR_IN1};
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        ovf_d      = ovf_q;
        if (ERR_CLR) begin
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            if (mismatch) begin
                err_flag_d = 1'b1;
                if (err_cnt_q != {ERRW{1'b1}}) err_cnt_d = err_cnt_q + ERRW'(1);
            end
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= S_IDLE;
            prev1_q    <= '0;
            prev2_q    <= '0;
            prev3_q    <= '0;
            sel3_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            prev1_q    <= prev1_d;
            prev2_q    <= prev2_d;
            prev3_q    <= prev3_d;
            sel3_q     <= sel3_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign SNAP_DATA  = mem_q[rd_ptr_q];
    assign SNAP_VALID = count_q != '0;
    assign FIFO_FULL  = count_q == FULL_CNT;
    assign ERR_CNT    = err_cnt_q;
    assign ERR_FLAG   = err_flag_q;
    assign OVF        = ovf_q;
endmodule

// File: tb/tb_cntr_sample_monitor.sv
// Directed bench for cntr_sample_monitor: a queue/arithmetic reference model is checked
// against the DUT every cycle, with literal expectations pinning the key scenarios.
module tb_cntr_sample_monitor;
    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int ERRW  = 8;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [2:0] c1, c2, c3;
    logic       sel3, chk_en, err_clr, snap_req, snap_ready;
    logic [8:0] snap_data;
    logic       snap_valid, err_flag, ovf, fifo_full;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         run;
    logic [2:0] m_prev1, m_prev2, m_prev3;
    logic       m_prev_sel;
    int         m_cnt;
    logic       m_flag, m_ovf;
    logic [8:0] q[$];

    localparam logic [8:0] EXP_SNAP [4] = '{9'o370, 9'o461, 9'o552, 9'o643};

    cntr_sample_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .CLK(clk), .RST_B(rst_b),
        .CNTR_IN1(c1), .CNTR_IN2(c2), .CNTR_IN3(c3),
        .SELECT_3(sel3), .CHK_EN(chk_en), .ERR_CLR(err_clr), .SNAP_REQ(snap_req),
        .SNAP_DATA(snap_data), .SNAP_VALID(snap_valid), .SNAP_READY(snap_ready),
        .ERR_CNT(err_cnt), .ERR_FLAG(err_flag), .OVF(ovf), .FIFO_FULL(fifo_full)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        run    = 0;
        m_cnt  = 0;
        m_flag = 1'b0;
        m_ovf  = 1'b0;
        q.delete();
    endtask

    // one rising edge of the specified behaviour, using the inputs the DUT just sampled
    task automatic model_edge();
        logic       mis;
        logic       pop;
        logic       drop;
        logic [2:0] e1, e2, e3;
        mis = 1'b0;
        e1 = m_prev1 + 3'd1;
        e2 = m_prev2 + 3'd1;
        e3 = m_prev3 + 3'd1;
        if (chk_en) begin
            if (run < 3) run++;
        end else begin
            run = 0;
        end
        if (chk_en && run >= 3) begin
            if (c1 != e1) mis = 1'b1;
            if (c2 != e2) mis = 1'b1;
            if (sel3 && m_prev_sel && c3 != e3) mis = 1'b1;
        end
        pop  = (q.size() > 0) && snap_ready;
        drop = snap_req && (q.size() == DEPTH) && !pop;
        if (!drop) begin
            if (pop) void'(q.pop_front());
            if (snap_req) q.push_back({c3, c2, c1});
        end
        if (err_clr) begin
            m_cnt  = 0;
            m_flag = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (mis) begin
                m_flag = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (drop) m_ovf = 1'b1;
        end
        m_prev1    = c1;
        m_prev2    = c2;
        m_prev3    = c3;
        m_prev_sel = sel3;
    endtask

    task automatic compare_all();
        chk("err_cnt",    32'(err_cnt),    32'(m_cnt));
        chk("err_flag",   32'(err_flag),   32'(m_flag));
        chk("ovf",        32'(ovf),        32'(m_ovf));
        chk("snap_valid", 32'(snap_valid), 32'(q.size() != 0));
        chk("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
        if (q.size() != 0) chk("snap_data", 32'(snap_data), 32'(q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv(input int i1, input int i2, input int i3);
        c1 = c1 + 3'(i1);
        c2 = c2 + 3'(i2);
        c3 = c3 + 3'(i3);
        step();
    endtask

    initial begin
        c1 = '0; c2 = '0; c3 = '0;
        sel3 = 1'b0; chk_en = 1'b0; err_clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        model_reset();

        // reset held with random inputs
        repeat (4) begin
            @(negedge clk);
            c1 = 3'($urandom); c2 = 3'($urandom); c3 = 3'($urandom);
            sel3 = 1'($urandom); chk_en = 1'($urandom); err_clr = 1'($urandom);
            snap_req = 1'($urandom); snap_ready = 1'($urandom);
        end
        @(negedge clk);
        chk("reset_err_cnt",    32'(err_cnt),    32'd0);
        chk("reset_err_flag",   32'(err_flag),   32'd0);
        chk("reset_ovf",        32'(ovf),        32'd0);
        chk("reset_snap_valid", 32'(snap_valid), 32'd0);
        chk("reset_fifo_full",  32'(fifo_full),  32'd0);
        chk("reset_snap_data",  32'(snap_data),  32'd0);

        // clean counting from an arbitrary ch1 start value
        chk_en = 1'b1; sel3 = 1'b1; err_clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        c1 = 3'($urandom); c2 = 3'd0; c3 = 3'd3;
        rst_b = 1'b1;
        compare_all();
        step();
        repeat (22) adv(1, 1, 1);
        chk("clean_err_cnt",  32'(err_cnt),  32'd0);
        chk("clean_err_flag", 32'(err_flag), 32'd0);

        // ch2 skips 3 -> 5
        for (int k = 0; k < 8 && c2 != 3'd3; k++) adv(1, 1, 1);
        adv(1, 2, 1);
        chk("skip_err_cnt",  32'(err_cnt),  32'd1);
        chk("skip_err_flag", 32'(err_flag), 32'd1);
        adv(1, 1, 1);
        adv(1, 1, 1);
        err_clr = 1'b1;
        adv(2, 1, 1);
        err_clr = 1'b0;
        chk("clr_wins_cnt",  32'(err_cnt),  32'd0);
        chk("clr_wins_flag", 32'(err_flag), 32'd0);
        repeat (3) adv(1, 1, 1);

        // bypass: ch3 held, then re-armed by SELECT_3 toggle
        sel3 = 1'b0;
        c3 = 3'd5;
        repeat (5) adv(1, 1, 0);
        chk("bypass_err_cnt", 32'(err_cnt), 32'd0);
        sel3 = 1'b1;
        c3 = 3'd2;
        adv(1, 1, 0);
        chk("toggle_no_err", 32'(err_cnt), 32'd0);
        repeat (3) adv(1, 1, 1);
        chk("ch3_count_ok", 32'(err_cnt), 32'd0);
        adv(1, 1, 3);
        chk("ch3_resumed", 32'(err_cnt), 32'd1);
        err_clr = 1'b1;
        adv(1, 1, 1);
        err_clr = 1'b0;

        // saturation: ch1 stuck for more than 255 checked cycles
        repeat (260) adv(0, 1, 1);
        chk("sat_err_cnt",  32'(err_cnt),  32'd255);
        chk("sat_err_flag", 32'(err_flag), 32'd1);
        err_clr = 1'b1;
        adv(1, 1, 1);
        err_clr = 1'b0;
        chk("sat_cleared", 32'(err_cnt), 32'd0);

        chk_en = 1'b0;
        repeat (2) adv(1, 1, 1);

        // fill and overflow with consumer stalled
        snap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c1 = 3'(i); c2 = 3'(7 - i); c3 = 3'(i + 3);
            snap_req = 1'b1;
            step();
            snap_req = 1'b0;
            step();
        end
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_ovf",  32'(ovf),       32'd1);
        snap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(snap_data), 32'(EXP_SNAP[i]));
            step();
        end
        chk("drained_empty", 32'(snap_valid), 32'd0);
        snap_ready = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // push and pop together while empty
        c1 = 3'd1; c2 = 3'd2; c3 = 3'd3;
        snap_req = 1'b1; snap_ready = 1'b1;
        step();
        chk("empty_pushpop_valid", 32'(snap_valid), 32'd1);
        chk("empty_pushpop_data",  32'(snap_data),  32'(9'o321));
        snap_req = 1'b0;
        step();

        // push and pop together while full
        snap_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c1 = 3'(i); c2 = 3'(i + 1); c3 = 3'(i + 2);
            snap_req = 1'b1;
            step();
        end
        c1 = 3'd7; c2 = 3'd7; c3 = 3'd7;
        snap_ready = 1'b1;
        step();
        chk("pushpop_full", 32'(fifo_full), 32'd1);
        chk("pushpop_ovf",  32'(ovf),       32'd0);
        snap_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("newest_last", 32'(snap_data), 32'(9'o777));
            step();
        end

        // overflow, partial drain, then reset mid-drain
        snap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c1 = 3'(i); c2 = 3'(i); c3 = 3'(i);
            snap_req = 1'b1;
            step();
        end
        snap_req = 1'b0;
        snap_ready = 1'b1;
        step();
        rst_b = 1'b0;
        #1;
        chk("midrst_valid", 32'(snap_valid), 32'd0);
        chk("midrst_full",  32'(fifo_full),  32'd0);
        chk("midrst_ovf",   32'(ovf),        32'd0);
        chk("midrst_data",  32'(snap_data),  32'd0);
        model_reset();
        @(negedge clk);
        snap_ready = 1'b0;
        chk_en = 1'b1; sel3 = 1'b1;
        c1 = 3'd6; c2 = 3'd1; c3 = 3'd4;
        rst_b = 1'b1;
        compare_all();
        step();
        repeat (8) adv(1, 1, 1);
        chk("rearm_err_cnt", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
